// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and state encoding for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int          c_nb_pc       = 32;
    localparam int          c_nb_inst     = 32;
    localparam int          c_nb_mem_addr = 8;
    localparam logic [31:0] c_halt_inst   = 32'hFFFF_FFFF;
    localparam logic [31:0] c_nop_inst    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Control, loader and IF/ID output bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if #(
    parameter int NB_PC       = 32,
    parameter int NB_INST     = 32,
    parameter int NB_MEM_ADDR = 8
) ();

    logic                   i_IF_enable;
    logic                   i_IF_pc_write;
    logic                   i_IF_flush;
    logic                   i_IF_branch;
    logic [NB_PC-1:0]       i_IF_branch_addr;
    logic                   i_IF_jump;
    logic [NB_PC-1:0]       i_IF_jump_addr;
    logic                   i_IF_jr;
    logic [NB_PC-1:0]       i_IF_jr_addr;
    logic                   i_IF_wr_en;
    logic [NB_MEM_ADDR-1:0] i_IF_wr_addr;
    logic [NB_INST-1:0]     i_IF_wr_data;
    logic [NB_INST-1:0]     o_IF_inst;
    logic [NB_PC-1:0]       o_IF_pc;
    logic [NB_PC-1:0]       o_IF_pc_value;
    logic                   o_IF_halt;

    modport master (
        output i_IF_enable, i_IF_pc_write, i_IF_flush,
        output i_IF_branch, i_IF_branch_addr, i_IF_jump, i_IF_jump_addr,
        output i_IF_jr, i_IF_jr_addr,
        output i_IF_wr_en, i_IF_wr_addr, i_IF_wr_data,
        input  o_IF_inst, o_IF_pc, o_IF_pc_value, o_IF_halt
    );

    modport slave (
        input  i_IF_enable, i_IF_pc_write, i_IF_flush,
        input  i_IF_branch, i_IF_branch_addr, i_IF_jump, i_IF_jump_addr,
        input  i_IF_jr, i_IF_jr_addr,
        input  i_IF_wr_en, i_IF_wr_addr, i_IF_wr_data,
        output o_IF_inst, o_IF_pc, o_IF_pc_value, o_IF_halt
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_instr_memory.sv
`default_nettype none
// ============================================================================
// Module      : instr_memory
// Description : Word-addressed instruction store, synchronous write and
//               combinational read (a same-cycle write is seen next cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_memory
    import if_stage_pkg::*;
#(
    parameter int NB_INST     = c_nb_inst,
    parameter int NB_MEM_ADDR = c_nb_mem_addr
) (
    input  wire logic                   i_clock,
    input  wire logic                   i_wr_en,
    input  wire logic [NB_MEM_ADDR-1:0] i_wr_addr,
    input  wire logic [NB_INST-1:0]     i_wr_data,
    input  wire logic [NB_MEM_ADDR-1:0] i_rd_addr,
    output      logic [NB_INST-1:0]     o_rd_data
);

    localparam int DEPTH = 2 ** NB_MEM_ADDR;

    logic [NB_INST-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : PC, next-PC select, load/run/halt control and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                 NB_PC       = c_nb_pc,
    parameter int                 NB_INST     = c_nb_inst,
    parameter int                 NB_MEM_ADDR = c_nb_mem_addr,
    parameter logic [NB_INST-1:0] HALT_INST   = NB_INST'(c_halt_inst)
) (
    input wire logic  i_clock,
    input wire logic  i_IF_reset,
    if_stage_if.slave bus
);

    localparam logic [NB_INST-1:0] NOP_INST = NB_INST'(c_nop_inst);

    state_e             state_q, state_d;
    logic [NB_PC-1:0]   pc_q, pc_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic [NB_PC-1:0]   npc_q, npc_d;

    logic [NB_INST-1:0] w_fetch;
    logic [NB_PC-1:0]   w_pc_plus1;
    logic [NB_PC-1:0]   w_target;
    logic               w_redirect;
    logic               w_is_halt;
    logic               w_mem_we;

    // The loader only owns the memory while the stage is idle.
    assign w_mem_we = bus.i_IF_wr_en && (state_q == ST_IDLE);

    instr_memory #(
        .NB_INST     (NB_INST),
        .NB_MEM_ADDR (NB_MEM_ADDR)
    ) u_instr_memory (
        .i_clock   (i_clock),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (bus.i_IF_wr_addr),
        .i_wr_data (bus.i_IF_wr_data),
        .i_rd_addr (pc_q[NB_MEM_ADDR-1:0]),
        .o_rd_data (w_fetch)
    );

    assign w_pc_plus1 = pc_q + NB_PC'(1);
    assign w_redirect = bus.i_IF_branch | bus.i_IF_jr | bus.i_IF_jump;
    assign w_is_halt  = (w_fetch == HALT_INST);

    always_comb begin
        w_target = bus.i_IF_jump_addr;
        if (bus.i_IF_branch) begin
            w_target = bus.i_IF_branch_addr;
        end else if (bus.i_IF_jr) begin
            w_target = bus.i_IF_jr_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        npc_d   = npc_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.i_IF_enable) begin
                    state_d = ST_RUN;
                    if (w_redirect) begin
                        pc_d = w_target;
                    end else if (bus.i_IF_pc_write) begin
                        pc_d = w_pc_plus1;
                    end

                    if (bus.i_IF_flush) begin
                        inst_d = NOP_INST;
                        npc_d  = '0;
                    end else if (bus.i_IF_pc_write) begin
                        if (w_is_halt && w_redirect) begin
                            // A redirect squashes a HALT fetched in the shadow.
                            inst_d = NOP_INST;
                            npc_d  = '0;
                        end else begin
                            inst_d = w_fetch;
                            npc_d  = w_pc_plus1;
                            if (w_is_halt) begin
                                state_d = ST_HALTED;
                                pc_d    = pc_q;
                            end
                        end
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_IF_reset) begin
        if (i_IF_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            npc_q   <= npc_d;
        end
    end

    assign bus.o_IF_inst     = inst_q;
    assign bus.o_IF_pc       = npc_q;
    assign bus.o_IF_pc_value = pc_q;
    assign bus.o_IF_halt     = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed scoreboard bench for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcv;
        logic        halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_kick;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_stage_if #(.NB_PC(32), .NB_INST(32), .NB_MEM_ADDR(8)) bus ();

    if_stage #(
        .NB_PC       (32),
        .NB_INST     (32),
        .NB_MEM_ADDR (8),
        .HALT_INST   (32'hFFFF_FFFF)
    ) dut (
        .i_clock    (clk),
        .i_IF_reset (rst),
        .bus        (bus)
    );

    task automatic clr_inputs();
        bus.i_IF_pc_write    = 1'b1;
        bus.i_IF_flush       = 1'b0;
        bus.i_IF_branch      = 1'b0;
        bus.i_IF_branch_addr = '0;
        bus.i_IF_jump        = 1'b0;
        bus.i_IF_jump_addr   = '0;
        bus.i_IF_jr          = 1'b0;
        bus.i_IF_jr_addr     = '0;
        bus.i_IF_wr_en       = 1'b0;
        bus.i_IF_wr_addr     = '0;
        bus.i_IF_wr_data     = '0;
    endtask

    task automatic push(input string nm, input logic [31:0] ei, input logic [31:0] ep,
                        input logic [31:0] epv, input logic eh);
        exp_t e;
        e.name = nm; e.inst = ei; e.pc = ep; e.pcv = epv; e.halt = eh;
        sb.push_back(e);
    endtask

    task automatic tick(input string nm, input logic [31:0] ei, input logic [31:0] ep,
                        input logic [31:0] epv, input logic eh);
        push(nm, ei, ep, epv, eh);
        @(posedge clk);
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic tick_nochk();
        @(posedge clk);
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        bus.i_IF_wr_en   = 1'b1;
        bus.i_IF_wr_addr = a;
        bus.i_IF_wr_data = d;
        tick_nochk();
    endtask

    // Monitor: outputs are sampled 1 time unit after each clock edge or kick.
    initial begin
        forever begin
            @(posedge clk or posedge mon_kick);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (bus.o_IF_inst === e.inst && bus.o_IF_pc === e.pc &&
                    bus.o_IF_pc_value === e.pcv && bus.o_IF_halt === e.halt) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got inst=%h pc=%h pcv=%h halt=%b, want inst=%h pc=%h pcv=%h halt=%b",
                             e.name, bus.o_IF_inst, bus.o_IF_pc, bus.o_IF_pc_value, bus.o_IF_halt,
                             e.inst, e.pc, e.pcv, e.halt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        mon_kick = 1'b0;
        bus.i_IF_enable = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk);
        tick("reset_state", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        tick("idle_hold", 32'h0, 32'h0, 32'h0, 1'b0);

        load(8'h00, 32'h2001_0005); load(8'h01, 32'h2002_0007);
        load(8'h02, 32'h0000_0022); load(8'h03, 32'h0000_0033);
        load(8'h04, 32'h0000_0044); load(8'h05, 32'h0000_0055);
        load(8'h06, 32'h0000_0066); load(8'h07, 32'h0000_0077);
        load(8'h08, 32'h0000_0088); load(8'h10, 32'h0000_1010);
        load(8'h20, 32'h0000_2020); load(8'h30, 32'h0000_3030);
        load(8'h31, 32'h0000_3131); load(8'hFF, 32'hFF00_FF00);

        // Continuous run; first fetch also overwrites index 0 (old word seen).
        bus.i_IF_enable  = 1'b1;
        bus.i_IF_wr_en   = 1'b1; bus.i_IF_wr_addr = 8'h00; bus.i_IF_wr_data = 32'hDEAD_BEEF;
        tick("fetch0", 32'h2001_0005, 32'h1, 32'h1, 1'b0);
        tick("fetch1", 32'h2002_0007, 32'h2, 32'h2, 1'b0);
        tick("fetch2", 32'h0000_0022, 32'h3, 32'h3, 1'b0);
        bus.i_IF_pc_write = 1'b0;
        bus.i_IF_wr_en    = 1'b1; bus.i_IF_wr_addr = 8'h04; bus.i_IF_wr_data = 32'h0000_0BAD;
        tick("stall_a", 32'h0000_0022, 32'h3, 32'h3, 1'b0);
        bus.i_IF_pc_write = 1'b0;
        tick("stall_b", 32'h0000_0022, 32'h3, 32'h3, 1'b0);
        tick("resume3", 32'h0000_0033, 32'h4, 32'h4, 1'b0);
        tick("run_write_ignored", 32'h0000_0044, 32'h5, 32'h5, 1'b0);

        bus.i_IF_branch = 1'b1; bus.i_IF_branch_addr = 32'h10;
        bus.i_IF_jr     = 1'b1; bus.i_IF_jr_addr     = 32'h20;
        bus.i_IF_jump   = 1'b1; bus.i_IF_jump_addr   = 32'h30;
        bus.i_IF_flush  = 1'b1;
        tick("prio_branch_flush", 32'h0, 32'h0, 32'h10, 1'b0);
        bus.i_IF_jr   = 1'b1; bus.i_IF_jr_addr   = 32'h20;
        bus.i_IF_jump = 1'b1; bus.i_IF_jump_addr = 32'h30;
        tick("prio_jr", 32'h0000_1010, 32'h11, 32'h20, 1'b0);
        tick("fetch_20", 32'h0000_2020, 32'h21, 32'h21, 1'b0);
        bus.i_IF_jump = 1'b1; bus.i_IF_jump_addr = 32'h30; bus.i_IF_pc_write = 1'b0;
        tick("jump_in_stall", 32'h0000_2020, 32'h21, 32'h30, 1'b0);
        bus.i_IF_enable = 1'b0;
        bus.i_IF_branch = 1'b1; bus.i_IF_branch_addr = 32'h0;
        tick("disabled_drop", 32'h0000_2020, 32'h21, 32'h30, 1'b0);
        bus.i_IF_enable = 1'b1;
        tick("fetch_30", 32'h0000_3030, 32'h31, 32'h31, 1'b0);
        bus.i_IF_branch = 1'b1; bus.i_IF_branch_addr = 32'h0;
        tick("branch_no_flush", 32'h0000_3131, 32'h32, 32'h0, 1'b0);
        tick("new_word_visible", 32'hDEAD_BEEF, 32'h1, 32'h1, 1'b0);
        bus.i_IF_jr = 1'b1; bus.i_IF_jr_addr = 32'h105;
        tick("jr_beyond_depth", 32'h2002_0007, 32'h2, 32'h105, 1'b0);
        tick("wrap_index", 32'h0000_0055, 32'h106, 32'h106, 1'b0);
        bus.i_IF_flush = 1'b1; bus.i_IF_pc_write = 1'b0;
        tick("flush_over_stall", 32'h0, 32'h0, 32'h106, 1'b0);

        // Step mode: one enable pulse every 4 cycles.
        bus.i_IF_enable = 1'b1;
        tick("step1", 32'h0000_0066, 32'h107, 32'h107, 1'b0);
        n_checks++;
        if (bus.o_IF_pc_value === 32'h107) begin
            n_pass++;
        end else begin
            $display("FAIL step1_pcv: got %h", bus.o_IF_pc_value);
        end
        bus.i_IF_enable = 1'b0;
        for (int k = 0; k < 3; k++) tick("step1_hold", 32'h0000_0066, 32'h107, 32'h107, 1'b0);
        bus.i_IF_enable = 1'b1;
        tick("step2", 32'h0000_0077, 32'h108, 32'h108, 1'b0);
        bus.i_IF_enable = 1'b0;
        for (int k = 0; k < 3; k++) tick("step2_hold", 32'h0000_0077, 32'h108, 32'h108, 1'b0);

        bus.i_IF_enable = 1'b1;
        bus.i_IF_jr = 1'b1; bus.i_IF_jr_addr = 32'hFFFF_FFFF;
        tick("jr_to_max", 32'h0000_0088, 32'h109, 32'hFFFF_FFFF, 1'b0);
        tick("pc_plus1_wrap", 32'hFF00_FF00, 32'h0, 32'h0, 1'b0);
        bus.i_IF_jump = 1'b1; bus.i_IF_jump_addr = 32'h5;
        tick("jump_to_5", 32'hDEAD_BEEF, 32'h1, 32'h5, 1'b0);

        // Asynchronous reset in the middle of the low phase.
        #2;
        rst = 1'b1;
        push("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        mon_kick = 1'b1;
        #2;
        mon_kick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.i_IF_enable = 1'b0;
        bus.i_IF_wr_en = 1'b1; bus.i_IF_wr_addr = 8'h02; bus.i_IF_wr_data = 32'hFFFF_FFFF;
        tick("idle_after_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (bus.o_IF_inst === 32'h0) begin
            n_pass++;
        end else begin
            $display("FAIL idle_inst: got %h", bus.o_IF_inst);
        end

        // HALT at index 2; further enables, redirects and writes are ignored.
        bus.i_IF_enable = 1'b1;
        tick("h_fetch0", 32'hDEAD_BEEF, 32'h1, 32'h1, 1'b0);
        tick("h_fetch1", 32'h2002_0007, 32'h2, 32'h2, 1'b0);
        tick("halt_fetch", 32'hFFFF_FFFF, 32'h3, 32'h2, 1'b1);
        n_checks++;
        if (bus.o_IF_halt === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL halt_flag: got %b", bus.o_IF_halt);
        end
        for (int k = 0; k < 10; k++) begin
            bus.i_IF_wr_en = 1'b1; bus.i_IF_wr_addr = 8'h02; bus.i_IF_wr_data = 32'h0;
            bus.i_IF_branch = k[0]; bus.i_IF_branch_addr = 32'h40;
            tick("halted_hold", 32'hFFFF_FFFF, 32'h3, 32'h2, 1'b1);
        end
        n_checks++;
        if (bus.o_IF_pc_value === 32'h2) begin
            n_pass++;
        end else begin
            $display("FAIL halted_pcv: got %h", bus.o_IF_pc_value);
        end

        rst = 1'b1;
        tick_nochk();
        rst = 1'b0;
        tick("s_fetch0", 32'hDEAD_BEEF, 32'h1, 32'h1, 1'b0);
        tick("s_fetch1", 32'h2002_0007, 32'h2, 32'h2, 1'b0);
        bus.i_IF_branch = 1'b1; bus.i_IF_branch_addr = 32'h10;
        tick("halt_squashed", 32'h0, 32'h0, 32'h10, 1'b0);
        bus.i_IF_jr = 1'b1; bus.i_IF_jr_addr = 32'h2;
        tick("jr_back_to_halt", 32'h0000_1010, 32'h11, 32'h2, 1'b0);
        tick("halt_again", 32'hFFFF_FFFF, 32'h3, 32'h2, 1'b1);

        bus.i_IF_enable = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: no sample taken, want inst=%h", e.name, e.inst);
        end
        if (n_pass == n_checks) begin
            $display("PASS");
        end else begin
            $display("FAIL summary");
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It holds the PC and a word-addressed instruction memory that the debug unit loads. Each enabled cycle it selects the next PC and presents a registered instruction and PC+1 to decode. The PC+1 value feeds decode's jump-address concatenation. The stage also detects the HALT word and freezes fetch.

Parameters:
NB_PC, 32, PC / address width
NB_INST, 32, instruction width
NB_MEM_ADDR, 8, instruction memory index width (depth = 2**NB_MEM_ADDR words)
HALT_INST, 32'hFFFF_FFFF, instruction word that stops fetch

Ports:
i_clock  in  1  stage clock
i_IF_reset  in  1  asynchronous active-high reset
i_IF_enable  in  1  global advance (debug unit; held 1 in continuous mode, 1-cycle pulse in step mode)
i_IF_pc_write  in  1  hazard unit; 0 = stall (hold PC and IF/ID)
i_IF_flush  in  1  control hazard; IF/ID loads NOP
i_IF_branch  in  1  branch taken (from MEM)
i_IF_branch_addr  in  NB_PC  branch target
i_IF_jump  in  1  J/JAL (from decode)
i_IF_jump_addr  in  NB_PC  jump target
i_IF_jr  in  1  JR/JALR (from decode)
i_IF_jr_addr  in  NB_PC  register target
i_IF_wr_en  in  1  debug loader write strobe
i_IF_wr_addr  in  NB_MEM_ADDR  loader word index
i_IF_wr_data  in  NB_INST  loader word
o_IF_inst  out  NB_INST  IF/ID instruction
o_IF_pc  out  NB_PC  IF/ID PC+1
o_IF_pc_value  out  NB_PC  current PC (debug readout)
o_IF_halt  out  1  fetch halted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: PC=0, o_IF_inst=0 (NOP), o_IF_pc=0, o_IF_halt=0, state=IDLE. Memory contents are not cleared.
- Addressing: word addressed. The fetch index is PC[NB_MEM_ADDR-1:0], so PCs beyond the memory depth wrap modulo the depth. PC+1 wraps at 2**NB_PC.
- Memory: the write is synchronous when i_IF_wr_en=1. The read is combinational from the current PC.
- Write-during-read to the current PC index: the fetch sees the old word; the new word is visible from the next cycle.
- FSM states:
  - IDLE: loader writes accepted; PC held at 0; IF/ID holds NOP. The first i_IF_enable=1 moves to RUN and performs a fetch in the same cycle.
  - RUN: loader writes ignored. On each cycle with enable=1 and no stall, fetch and update as below.
  - HALTED: PC and IF/ID frozen; o_IF_halt=1; writes ignored. Only reset exits.
- RUN update, when enable=1:
  - Next-PC priority: branch > jr > jump > PC+1.
  - A redirect (branch/jr/jump) loads PC even when i_IF_pc_write=0.
  - Without a redirect, pc_write=0 holds PC.
- IF/ID register, when enable=1:
  - flush=1: o_IF_inst=0, o_IF_pc=0. Flush overrides stall.
  - Else pc_write=0: hold.
  - Else: o_IF_inst=mem[PC], o_IF_pc=PC+1.
- Latency: an instruction at PC appears on o_IF_inst one cycle after PC is current.
- enable=0: every register holds. This includes held redirects, which are dropped; the upstream stage must hold its request until it is accepted.
- HALT:
  - When mem[PC]==HALT_INST is latched into IF/ID (not flushed), HALT_INST is passed down so later stages can drain.
  - The state goes to HALTED in the same edge and o_IF_halt rises on that edge; PC stays at the HALT address.
  - If flush or redirect coincides with the HALT fetch, the HALT is squashed, the redirect wins, and there is no halt.
- Reset mid-operation: the asynchronous return to IDLE and reset values takes effect regardless of state.

Decomposition:
- Shared package: HALT_INST, the NOP constant, state encodings (IDLE/RUN/HALTED), NB_PC and NB_INST defaults.
- Sub-module instr_memory (write port, combinational read port), instantiated once. The PC mux, FSM and IF/ID register stay in if_stage.

Test Plan:
1. Loader writes 0x20010005 @0 and 0x20020007 @1, reset released, then enable=1 continuous -> after the first edge o_IF_inst=0x20010005, o_IF_pc=1; after the second, o_IF_inst=0x20020007, o_IF_pc=2.
2. Stall: pc_write=0 for 2 cycles at PC=3 -> PC, o_IF_inst and o_IF_pc unchanged for 2 cycles, then resume at PC=4.
3. Redirect priority: branch=1 (0x10), jr=1 (0x20) and jump=1 (0x30) in the same cycle, with flush=1 -> next PC=0x10 and o_IF_inst=0. Repeat with jr and jump only -> next PC=0x20.
4. HALT: mem[2]=0xFFFFFFFF -> at the third fetch o_IF_inst=0xFFFFFFFF and o_IF_halt=1; PC stays at 2 for 10 more cycles; loader writes ignored.
5. Step mode: enable pulsed once every 4 cycles -> PC advances exactly 1 per pulse; outputs stable between pulses.
6. Asynchronous reset asserted mid-cycle while in RUN at PC=5 -> outputs go to 0 immediately without waiting for a clock edge; state is IDLE; a loader write is then accepted.
